// File: rtl/avalon_pio_out_bank.sv
// avalon_pio_out_bank: Avalon-MM bank of output registers with set/clear,
// self-clearing timed pulses and per-channel change strobes.
module avalon_pio_out_bank #(
    parameter int               WIDTH        = 32,
    parameter int               CHANNELS     = 4,
    parameter int               PULSE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               ADDR_W       = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic [WIDTH*CHANNELS-1:0] out_port,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       changed
);
    localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
    localparam int CH_W  = ADDR_W > 2 ? ADDR_W - 2 : 1;

    logic [CHANNELS-1:0][WIDTH-1:0] data_q, data_d, mask_q, mask_d;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]            changed_q, changed_d;
    logic [CH_W-1:0]                ch;
    logic [1:0]                     rsel;
    logic [WIDTH-1:0]               wd;
    logic                           wr;
    logic                           unused_wd;

    if (ADDR_W > 2) begin : g_ch
        assign ch = address[ADDR_W-1:2];
    end else begin : g_noch
        assign ch = '0;
    end

    assign rsel      = address[1:0];
    assign wd        = writedata[WIDTH-1:0];
    assign wr        = chipselect & ~write_n;
    assign unused_wd = ^writedata;
    assign out_port  = data_q;
    assign changed   = changed_q;

    // Expiry is applied first so a same-edge bus write sees the post-expiry state.
    always_comb begin
        data_d    = data_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        changed_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cnt_q[c] == CNT_W'(1)) begin
                data_d[c] = data_q[c] & ~mask_q[c];
                mask_d[c] = '0;
            end
            cnt_d[c] = (cnt_q[c] > CNT_W'(1)) ? cnt_q[c] - CNT_W'(1) : '0;
            if (wr && ch == CH_W'(c)) begin
                case (rsel)
                    2'd0: begin
                        data_d[c] = wd;
                        mask_d[c] = '0;
                        cnt_d[c]  = '0;
                    end
                    2'd1: data_d[c] = data_d[c] | wd;
                    2'd2: begin
                        data_d[c] = data_d[c] & ~wd;
                        mask_d[c] = mask_d[c] & ~wd;
                        cnt_d[c]  = (mask_d[c] == '0) ? '0 : cnt_d[c];
                    end
                    default: begin
                        if (wd != '0) begin
                            data_d[c] = data_d[c] | wd;
                            mask_d[c] = mask_d[c] | wd;
                            cnt_d[c]  = CNT_W'(PULSE_CYCLES);
                        end
                    end
                endcase
            end
            changed_d[c] = data_d[c] != data_q[c];
        end
    end

    always_comb begin
        busy     = '0;
        readdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            busy[c] = cnt_q[c] != '0;
            if (ch == CH_W'(c))
                readdata = rsel == 2'd0 ? 32'(data_q[c]) :
                           rsel == 2'd3 ? {cnt_q[c] != '0, 15'd0, 16'(cnt_q[c])} : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= {CHANNELS{RESET_VALUE}};
            mask_q    <= '0;
            cnt_q     <= '0;
            changed_q <= '0;
        end else begin
            data_q    <= data_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
        end
    end
endmodule

// File: tb/tb_avalon_pio_out_bank.sv
// tb_avalon_pio_out_bank: directed scoreboard bench for the output-port bank.
module tb_avalon_pio_out_bank;
    localparam int          W  = 32;
    localparam int          CH = 3;
    localparam int          PC = 16;
    localparam int          AW = 4;
    localparam logic [31:0] RV = 32'h1234_5600;

    typedef struct {
        string       tag;
        logic [63:0] v;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            chipselect = 1'b0;
    logic            write_n = 1'b1;
    logic [AW-1:0]   address = '0;
    logic [31:0]     writedata = '0;
    logic [31:0]     readdata;
    logic [W*CH-1:0] out_port;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   changed;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          hi0, hi1, last0, last1, nbusy, nchg;
    logic [31:0] rd_first, rd_last, rd;

    avalon_pio_out_bank #(
        .WIDTH(W), .CHANNELS(CH), .PULSE_CYCLES(PC), .RESET_VALUE(RV), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .busy(busy), .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        sbq.push_back('{tag, v});
    endtask

    task automatic pop_check(input logic [63:0] got);
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_empty", 64'(sbq.size()), 64'd1);
        end else begin
            e = sbq.pop_front();
            check(e.tag, got, e.v);
        end
    endtask

    function automatic logic [31:0] ch_out(input int c);
        return out_port[c*W +: W];
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd_at(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = readdata;
    endtask

    // Start a pulse on channel 0, optionally inject one write at sample wcyc,
    // and gather per-bit high counts, busy/changed counts and counter reads.
    task automatic pulse_run(input logic [31:0] pw, input int ncyc, input int wcyc,
                             input logic [3:0] wa, input logic [31:0] wd);
        hi0 = 0; hi1 = 0; last0 = 0; last1 = 0; nbusy = 0; nchg = 0;
        wr(4'd3, pw);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (out_port[0]) begin hi0++; last0 = k; end
            if (out_port[1]) begin hi1++; last1 = k; end
            if (busy[0]) nbusy++;
            if (changed[0]) nchg++;
            chipselect = (k == wcyc);
            write_n = !(k == wcyc);
            address = (k == wcyc) ? wa : 4'd3;
            writedata = wd;
            #1;
            if (k == 1) rd_first = readdata;
            if (k == ncyc) rd_last = readdata;
        end
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic wr_ch1(input logic [3:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input logic chg);
        push("ch1_out", exp);
        push("ch1_changed", chg);
        wr(a, d);
        @(negedge clk);
        pop_check(ch_out(1));
        pop_check(changed[1]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < CH; c++) push("rst_out", RV);
        push("rst_busy", 0);
        push("rst_changed", 0);
        push("rst_rd0", RV);
        @(negedge clk);
        for (int c = 0; c < CH; c++) pop_check(ch_out(c));
        pop_check(busy);
        pop_check(changed);
        rd_at(4'd0, rd);
        pop_check(rd);

        wr_ch1(4'd4, 32'h0000_00F0, 32'h0000_00F0, 1'b1);
        wr_ch1(4'd5, 32'h0000_000F, 32'h0000_00FF, 1'b1);
        wr_ch1(4'd6, 32'h0000_0030, 32'h0000_00CF, 1'b1);
        wr_ch1(4'd5, 32'h0000_000F, 32'h0000_00CF, 1'b0);
        push("rd_data1", 32'hCF);
        push("rd_set1", 0);
        push("rd_clr1", 0);
        push("rd_pulse1", 0);
        rd_at(4'd4, rd); pop_check(rd);
        rd_at(4'd5, rd); pop_check(rd);
        rd_at(4'd6, rd); pop_check(rd);
        rd_at(4'd7, rd); pop_check(rd);

        push("p_hi0", PC); push("p_busy", PC); push("p_chg", 2);
        push("p_rd_first", 32'h8000_0000 | PC); push("p_rd_last", 0); push("p_rest", RV);
        pulse_run(32'h1, 20, 0, 4'd0, 32'h0);
        pop_check(hi0); pop_check(nbusy); pop_check(nchg);
        pop_check(rd_first); pop_check(rd_last); pop_check(ch_out(0));

        push("ext_hi0", 24); push("ext_hi1", 16); push("ext_last0", 24);
        push("ext_last1", 24); push("ext_busy", 24); push("ext_chg", 3);
        pulse_run(32'h1, 30, 8, 4'd3, 32'h2);
        pop_check(hi0); pop_check(hi1); pop_check(last0);
        pop_check(last1); pop_check(nbusy); pop_check(nchg);

        push("clr0_hi0", 5); push("clr0_hi1", 16); push("clr0_last1", 16);
        push("clr0_busy", 16); push("clr0_chg", 3);
        pulse_run(32'h3, 20, 5, 4'd2, 32'h1);
        pop_check(hi0); pop_check(hi1); pop_check(last1);
        pop_check(nbusy); pop_check(nchg);

        push("clr3_hi0", 5); push("clr3_hi1", 5); push("clr3_busy", 5);
        push("clr3_chg", 2); push("clr3_rd_last", 0);
        pulse_run(32'h3, 20, 5, 4'd2, 32'h3);
        pop_check(hi0); pop_check(hi1); pop_check(nbusy);
        pop_check(nchg); pop_check(rd_last);

        push("data_hi0", 30); push("data_busy", 5); push("data_chg", 2); push("data_out", 1);
        pulse_run(32'h1, 30, 5, 4'd0, 32'h1);
        pop_check(hi0); pop_check(nbusy); pop_check(nchg); pop_check(ch_out(0));
        wr(4'd0, RV);

        push("exp_hi0", 16); push("exp_hi1", 16); push("exp_last1", 32);
        push("exp_busy", 32); push("exp_chg", 3); push("exp_rd_last", 0);
        pulse_run(32'h1, 40, 16, 4'd3, 32'h2);
        pop_check(hi0); pop_check(hi1); pop_check(last1);
        pop_check(nbusy); pop_check(nchg); pop_check(rd_last);

        push("unused_ch0", RV); push("unused_ch1", 32'hCF); push("unused_ch2", RV);
        push("unused_changed", 0); push("unused_rd12", 0); push("unused_rd15", 0);
        wr(4'd12, 32'hFFFF_FFFF);
        @(negedge clk);
        pop_check(ch_out(0)); pop_check(ch_out(1)); pop_check(ch_out(2));
        pop_check(changed);
        rd_at(4'd12, rd); pop_check(rd);
        rd_at(4'd15, rd); pop_check(rd);

        push("arst_ch0", RV); push("arst_ch1", RV); push("arst_busy", 0);
        push("arst_changed", 0); push("arst_rd3", 0);
        push("post_ch0", RV); push("post_busy", 0);
        wr(4'd3, 32'h1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        pop_check(ch_out(0)); pop_check(ch_out(1));
        pop_check(busy); pop_check(changed);
        address = 4'd3;
        #1;
        pop_check(readdata);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        pop_check(ch_out(0)); pop_check(busy);

        if (sbq.size() != 0) check("sb_leftover", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
